// File: rtl/trellis_neighbor_checker_pipe_pkg.sv
// rtl/trellis_neighbor_checker_pipe_pkg.sv - shared types, constants and saturation helpers
package tnc_pkg;

   localparam int TNC_PIPE_LAT = 3;

   typedef enum logic [1:0] {IDLE, COMPUTE, READY} tnc_state_t;

   function automatic int flag_w(input int n);
      return $clog2(2 * n + 1);
   endfunction

   function automatic int sat_err(input int x, input int bw);
      int hi;
      int lo;
      hi = (1 << (bw - 1)) - 1;
      lo = -(1 << (bw - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic int sat_ener(input int x, input int bw);
      int hi;
      hi = (1 << bw) - 1;
      return (x > hi) ? hi : x;
   endfunction

endpackage

// File: rtl/trellis_neighbor_checker_pipe_if.sv
// rtl/trellis_neighbor_checker_pipe_if.sv - error-block input and flag output bundle
interface trellis_neighbor_checker_pipe_if #(
   parameter int width            = 16,
   parameter int est_err_bitwidth = 9,
   parameter int ener_bitwidth    = 18,
   parameter int flag_bitwidth    = 4
);
   logic [width-1:0][est_err_bitwidth-1:0] errstream;
   logic                                   errstream_valid;
   logic [width-1:0][flag_bitwidth-1:0]    flags;
   logic [width-1:0][ener_bitwidth-1:0]    flag_eners;
   logic                                   flags_valid;

   modport master (
      output errstream, errstream_valid,
      input  flags, flag_eners, flags_valid
   );

   modport slave (
      input  errstream, errstream_valid,
      output flags, flag_eners, flags_valid
   );
endinterface

// File: rtl/trellis_neighbor_checker_pipe_ies_engine.sv
// rtl/trellis_neighbor_checker_pipe_ies_engine.sv - config shadow, injection sequence FSM and storage
module tnc_ies_engine
   import tnc_pkg::*;
#(
   parameter int est_channel_bitwidth    = 10,
   parameter int depth                   = 30,
   parameter int branch_bitwidth         = 2,
   parameter int shift_bitwidth          = 3,
   parameter int num_of_trellis_patterns = 4,
   parameter int trellis_pattern_depth   = 4,
   parameter int seq_length              = 3,
   parameter int est_err_bitwidth        = 9
) (
   input  logic clk,
   input  logic rstb,
   input  logic [depth-1:0][est_channel_bitwidth-1:0] channel,
   input  logic [shift_bitwidth-1:0] channel_shift,
   input  logic [num_of_trellis_patterns-1:0][trellis_pattern_depth-1:0][branch_bitwidth-1:0] trellis_patterns,
   input  logic nrz_mode,
   input  logic cfg_update,
   output logic cfg_ready,
   output logic [2*num_of_trellis_patterns-1:0][seq_length-1:0][est_err_bitwidth-1:0] ies
);
   localparam int N   = num_of_trellis_patterns;
   localparam int TPD = trellis_pattern_depth;
   localparam int SL  = seq_length;
   localparam int EW  = est_err_bitwidth;
   localparam int CHN = SL + TPD - 1;
   localparam int PW  = (N > 1) ? $clog2(N) : 1;

   tnc_state_t state, state_nxt;
   logic [PW-1:0] p;
   logic [CHN-1:0][est_channel_bitwidth-1:0] ch_sh;
   logic [shift_bitwidth-1:0] shift_sh;
   logic [N-1:0][TPD-1:0][branch_bitwidth-1:0] pat_sh;
   logic nrz_sh;
   logic [TPD-1:0][branch_bitwidth-1:0] pat_cur;
   logic [SL-1:0][EW-1:0] seq_pos, seq_neg;

   // Taps past the injection window never contribute to any sequence.
   generate
      if (depth > CHN) begin : g_unused_taps
         logic unused_taps;
         assign unused_taps = ^channel[depth-1:CHN];
      end
   endgenerate

   assign cfg_ready = (state == READY);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cfg_update) begin
         state_nxt = COMPUTE;
      end else begin
         case (state)
            COMPUTE: if (p == PW'(N - 1)) state_nxt = READY;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin : seq_calc
      int acc;
      int scale;
      pat_cur = '0;
      seq_pos = '0;
      seq_neg = '0;
      for (int q = 0; q < N; q++)
         if (p == PW'(q)) pat_cur = pat_sh[q];
      scale = nrz_sh ? 2 : 1;
      for (int k = 0; k < SL; k++) begin
         acc = 0;
         for (int j = 0; j < TPD; j++)
            acc += scale * int'($signed(pat_cur[j])) * int'($signed(ch_sh[k+j]));
         acc = acc >>> channel_shift_sel(shift_sh);
         seq_pos[k] = EW'(sat_err(acc, EW));
         seq_neg[k] = EW'(sat_err(-sat_err(acc, EW), EW));
      end
   end

   function automatic int channel_shift_sel(input logic [shift_bitwidth-1:0] s);
      return int'(s);
   endfunction

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         p        <= '0;
         ch_sh    <= '0;
         shift_sh <= '0;
         pat_sh   <= '0;
         nrz_sh   <= 1'b0;
         ies      <= '0;
      end else if (cfg_update) begin
         p        <= '0;
         ch_sh    <= channel[CHN-1:0];
         shift_sh <= channel_shift;
         pat_sh   <= trellis_patterns;
         nrz_sh   <= nrz_mode;
      end else if (state == COMPUTE) begin
         for (int q = 0; q < N; q++) begin
            if (p == PW'(q)) begin
               ies[q]   <= seq_pos;
               ies[q+N] <= seq_neg;
            end
         end
         p <= p + 1'b1;
      end
   end

endmodule

// File: rtl/trellis_neighbor_checker_pipe.sv
// rtl/trellis_neighbor_checker_pipe.sv - pipelined per-lane lowest-energy neighbour flagger
module trellis_neighbor_checker_pipe
   import tnc_pkg::*;
#(
   parameter int est_channel_bitwidth    = 10,
   parameter int depth                   = 30,
   parameter int width                   = 16,
   parameter int branch_bitwidth         = 2,
   parameter int shift_bitwidth          = 3,
   parameter int num_of_trellis_patterns = 4,
   parameter int trellis_pattern_depth   = 4,
   parameter int seq_length              = 3,
   parameter int ener_bitwidth           = 18,
   parameter int est_err_bitwidth        = 9
) (
   input  logic clk,
   input  logic rstb,
   input  logic [depth-1:0][est_channel_bitwidth-1:0] channel,
   input  logic [shift_bitwidth-1:0] channel_shift,
   input  logic [num_of_trellis_patterns-1:0][trellis_pattern_depth-1:0][branch_bitwidth-1:0] trellis_patterns,
   input  logic nrz_mode,
   input  logic cfg_update,
   output logic cfg_ready,
   input  logic [ener_bitwidth-1:0] ener_margin,
   trellis_neighbor_checker_pipe_if.slave bus
);
   localparam int N   = num_of_trellis_patterns;
   localparam int NC  = 2 * N;
   localparam int SL  = seq_length;
   localparam int EW  = est_err_bitwidth;
   localparam int EB  = ener_bitwidth;
   localparam int FW  = flag_w(N);
   localparam int EXT = width + SL - 1;

   logic [NC-1:0][SL-1:0][EW-1:0] ies;
   logic signed [EW-1:0] hist_q [SL-1];
   logic signed [EW-1:0] ext_q [EXT];
   logic v1, v2, rdy2;

   tnc_ies_engine #(
      .est_channel_bitwidth   (est_channel_bitwidth),
      .depth                  (depth),
      .branch_bitwidth        (branch_bitwidth),
      .shift_bitwidth         (shift_bitwidth),
      .num_of_trellis_patterns(N),
      .trellis_pattern_depth  (trellis_pattern_depth),
      .seq_length             (SL),
      .est_err_bitwidth       (EW)
   ) u_ies (
      .clk             (clk),
      .rstb            (rstb),
      .channel         (channel),
      .channel_shift   (channel_shift),
      .trellis_patterns(trellis_patterns),
      .nrz_mode        (nrz_mode),
      .cfg_update      (cfg_update),
      .cfg_ready       (cfg_ready),
      .ies             (ies)
   );

   // Stage 1 captures the extended window; the tail of each block seeds the next one.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < SL-1; i++) hist_q[i] <= '0;
         for (int i = 0; i < EXT; i++)  ext_q[i]  <= '0;
         v1               <= 1'b0;
         v2               <= 1'b0;
         rdy2             <= 1'b0;
         bus.flags_valid  <= 1'b0;
      end else begin
         v1              <= bus.errstream_valid;
         v2              <= v1;
         bus.flags_valid <= v2;
         if (v1) rdy2 <= cfg_ready;
         if (bus.errstream_valid) begin
            for (int i = 0; i < SL-1; i++) begin
               ext_q[i]  <= hist_q[i];
               hist_q[i] <= $signed(bus.errstream[width-SL+1+i]);
            end
            for (int i = 0; i < width; i++)
               ext_q[SL-1+i] <= $signed(bus.errstream[i]);
         end
      end
   end

   generate
      for (genvar g = 0; g < width; g++) begin : g_lane
         int nul_c;
         int cand_c [NC];
         logic [EB-1:0] null_q;
         logic [EB-1:0] cand_q [NC];
         logic [EB-1:0] best;
         logic [FW-1:0] best_idx;
         logic win;
         logic [FW-1:0] flag_q;
         logic [EB-1:0] ener_q;

         always_comb begin : energy
            int e;
            int d;
            nul_c = 0;
            for (int c = 0; c < NC; c++) cand_c[c] = 0;
            for (int k = 0; k < SL; k++) begin
               e = int'(ext_q[g+k]);
               nul_c += e * e;
               for (int c = 0; c < NC; c++) begin
                  d = e - int'($signed(ies[c][k]));
                  cand_c[c] += d * d;
               end
            end
         end

         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               null_q <= '0;
               for (int c = 0; c < NC; c++) cand_q[c] <= '0;
            end else if (v1) begin
               null_q <= EB'(sat_ener(nul_c, EB));
               for (int c = 0; c < NC; c++) cand_q[c] <= EB'(sat_ener(cand_c[c], EB));
            end
         end

         // Strict less-than keeps the lowest candidate index on ties.
         always_comb begin : pick
            best     = cand_q[0];
            best_idx = '0;
            for (int c = 1; c < NC; c++) begin
               if (cand_q[c] < best) begin
                  best     = cand_q[c];
                  best_idx = FW'(c);
               end
            end
            win = rdy2 && (({1'b0, best} + {1'b0, ener_margin}) < {1'b0, null_q});
         end

         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               flag_q <= '0;
               ener_q <= '0;
            end else if (v2) begin
               flag_q <= win ? best_idx + 1'b1 : '0;
               ener_q <= win ? best : null_q;
            end
         end

         assign bus.flags[g]      = flag_q;
         assign bus.flag_eners[g] = ener_q;
      end
   endgenerate

endmodule

// File: tb/tb_trellis_neighbor_checker_pipe.sv
// tb/tb_trellis_neighbor_checker_pipe.sv - randomized bench against a behavioural reference model
module tb_trellis_neighbor_checker_pipe;
   import tnc_pkg::*;

   localparam int CW = 10, DEPTH = 30, WIDTH = 16, BB = 2, SHW = 3, N = 4, TPD = 4, SL = 3;
   localparam int EB = 18, EW = 9, NC = 2 * N, FW = flag_w(N), EXT = WIDTH + SL - 1;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   logic [DEPTH-1:0][CW-1:0]      channel;
   logic [SHW-1:0]                channel_shift;
   logic [N-1:0][TPD-1:0][BB-1:0] trellis_patterns;
   logic                          nrz_mode;
   logic                          cfg_update;
   logic                          cfg_ready;
   logic [EB-1:0]                 ener_margin;

   trellis_neighbor_checker_pipe_if #(
      .width(WIDTH), .est_err_bitwidth(EW), .ener_bitwidth(EB), .flag_bitwidth(FW)
   ) bus ();

   trellis_neighbor_checker_pipe dut (
      .clk             (clk),
      .rstb            (rstb),
      .channel         (channel),
      .channel_shift   (channel_shift),
      .trellis_patterns(trellis_patterns),
      .nrz_mode        (nrz_mode),
      .cfg_update      (cfg_update),
      .cfg_ready       (cfg_ready),
      .ener_margin     (ener_margin),
      .bus             (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct {
      int                       due;
      logic [WIDTH*FW-1:0]      f;
      logic [WIDTH*EB-1:0]      e;
   } exp_t;

   exp_t expq[$];
   int hist[SL-1];
   int ies_ref[NC][SL];
   int errv[WIDTH];
   int ready_at = -1;
   int edge_n = 0;

   function automatic int clampi(input int x, input int bw);
      int hi;
      int lo;
      hi = (1 << (bw - 1)) - 1;
      lo = -(1 << (bw - 1));
      return (x > hi) ? hi : ((x < lo) ? lo : x);
   endfunction

   function automatic int esat(input int x);
      return (x > (1 << EB) - 1) ? (1 << EB) - 1 : x;
   endfunction

   // Injection sequences straight from the definition: scaled pattern convolved with the taps.
   task automatic compute_ies_ref();
      int s;
      int acc;
      s = nrz_mode ? 2 : 1;
      for (int p = 0; p < N; p++) begin
         for (int k = 0; k < SL; k++) begin
            acc = 0;
            for (int j = 0; j < TPD; j++)
               acc += s * int'($signed(trellis_patterns[p][j])) * int'($signed(channel[k+j]));
            ies_ref[p][k]   = clampi(acc >>> int'(channel_shift), EW);
            ies_ref[p+N][k] = clampi(-ies_ref[p][k], EW);
         end
      end
   endtask

   task automatic model_block();
      int ext[EXT];
      int nul, ce, best, bi, fl, en;
      bit rdy;
      exp_t x;
      rdy = (ready_at >= 0) && (edge_n >= ready_at);
      for (int i = 0; i < SL-1; i++) ext[i] = hist[i];
      for (int i = 0; i < WIDTH; i++) ext[SL-1+i] = errv[i];
      x.f = '0;
      x.e = '0;
      for (int g = 0; g < WIDTH; g++) begin
         nul = 0;
         for (int k = 0; k < SL; k++) nul += ext[g+k] * ext[g+k];
         nul = esat(nul);
         best = -1;
         bi = 0;
         for (int c = 0; c < NC; c++) begin
            ce = 0;
            for (int k = 0; k < SL; k++) ce += (ext[g+k] - ies_ref[c][k]) * (ext[g+k] - ies_ref[c][k]);
            ce = esat(ce);
            if (best < 0 || ce < best) begin best = ce; bi = c; end
         end
         if (rdy && (best + int'(ener_margin) < nul)) begin fl = bi + 1; en = best; end
         else begin fl = 0; en = nul; end
         x.f[g*FW +: FW] = FW'(fl);
         x.e[g*EB +: EB] = EB'(en);
      end
      for (int i = 0; i < SL-1; i++) hist[i] = errv[WIDTH-SL+1+i];
      x.due = edge_n + TNC_PIPE_LAT - 1;
      expq.push_back(x);
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      edge_n++;
      if (rstb) begin
         if (cfg_update) begin
            compute_ies_ref();
            ready_at = edge_n + N;
         end
         if (bus.errstream_valid) model_block();
      end
      #1;
      check_val("cfg_ready", cfg_ready, (ready_at >= 0 && edge_n >= ready_at));
      if (expq.size() > 0 && expq[0].due == edge_n) begin
         x = expq.pop_front();
         check_val("flags_valid", bus.flags_valid, 1);
         check_val("flags", bus.flags, x.f);
         check_val("flag_eners", bus.flag_eners, x.e);
      end else begin
         check_val("flags_valid_idle", bus.flags_valid, 0);
      end
      cfg_update          = 1'b0;
      bus.errstream_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send();
      for (int i = 0; i < WIDTH; i++) begin
         errv[i] = clampi(errv[i], EW);
         bus.errstream[i] = EW'(errv[i]);
      end
      bus.errstream_valid = 1'b1;
      tick();
   endtask

   task automatic clear_errv();
      for (int i = 0; i < WIDTH; i++) errv[i] = 0;
   endtask

   task automatic base_cfg(input int ch0);
      channel = '0;
      channel[0] = CW'(ch0);
      channel[1] = CW'(10);
      trellis_patterns = '0;
      trellis_patterns[0][0] = BB'(1);
      channel_shift = '0;
      nrz_mode = 1'b0;
   endtask

   task automatic random_cfg();
      for (int i = 0; i < DEPTH; i++) channel[i] = CW'(int'($urandom_range(0, 1023)) - 512);
      for (int p = 0; p < N; p++)
         for (int j = 0; j < TPD; j++) trellis_patterns[p][j] = BB'($urandom_range(0, 3));
      channel_shift = SHW'($urandom_range(0, 7));
      nrz_mode = 1'($urandom_range(0, 1));
   endtask

   task automatic single_stim(input int sgn);
      clear_errv();
      errv[3] = 20 * sgn;
      errv[4] = 10 * sgn;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, c;
      channel = '0;
      channel_shift = '0;
      trellis_patterns = '0;
      nrz_mode = 1'b0;
      cfg_update = 1'b0;
      ener_margin = '0;
      bus.errstream = '0;
      bus.errstream_valid = 1'b0;
      for (int i = 0; i < SL-1; i++) hist[i] = 0;
      for (int p = 0; p < NC; p++) for (int k = 0; k < SL; k++) ies_ref[p][k] = 0;
      clear_errv();

      idle(2);
      check_val("rst_flags", bus.flags, 0);
      check_val("rst_eners", bus.flag_eners, 0);
      #2 rstb = 1'b1;

      // Sequence computation; live taps scrambled after the update must not matter.
      base_cfg(20);
      cfg_update = 1'b1;
      tick();
      channel = '1;
      idle(4);
      check_val("ready_after_4", cfg_ready, 1);

      single_stim(1);
      send();
      idle(2);
      check_val("lane5_flag", bus.flags[5], 1);
      check_val("lane5_ener", bus.flag_eners[5], 0);
      check_val("lane4_flag", bus.flags[4], 0);
      check_val("lane4_ener", bus.flag_eners[4], 500);
      check_val("lane6_flag", bus.flags[6], 0);
      check_val("lane6_ener", bus.flag_eners[6], 100);

      single_stim(-1);
      send();
      idle(2);
      check_val("neg_lane5_flag", bus.flags[5], 5);

      clear_errv(); errv[15] = 20; send();
      clear_errv(); errv[0] = 10;  send();
      idle(2);
      check_val("hist_flag", bus.flags[1], 1);
      check_val("hist_ener", bus.flag_eners[1], 0);
      clear_errv(); errv[15] = 20; send();
      idle(5);
      clear_errv(); errv[0] = 10;  send();
      idle(2);
      check_val("hist_gap_flag", bus.flags[1], 1);
      check_val("hist_gap_ener", bus.flag_eners[1], 0);

      ener_margin = EB'(600);
      single_stim(1); send(); idle(2);
      check_val("margin600_flag", bus.flags[5], 0);
      check_val("margin600_ener", bus.flag_eners[5], 500);
      ener_margin = EB'(499);
      single_stim(1); send(); idle(2);
      check_val("margin499_flag", bus.flags[5], 1);
      ener_margin = '0;

      // Restart during COMPUTE with blocks flowing.
      base_cfg(20);
      single_stim(1);
      cfg_update = 1'b1; send();
      send();
      base_cfg(30);
      cfg_update = 1'b1; send();
      send();
      idle(6);
      single_stim(1); errv[3] = 30; send(); idle(2);
      check_val("restart_flag", bus.flags[5], 1);

      // Reset mid-COMPUTE with valids in flight.
      cfg_update = 1'b1; tick();
      clear_errv(); errv[14] = 100; errv[15] = -100; send();
      send();
      #2 rstb = 1'b0;
      #1;
      check_val("arst_flags", bus.flags, 0);
      check_val("arst_eners", bus.flag_eners, 0);
      check_val("arst_valid", bus.flags_valid, 0);
      check_val("arst_ready", cfg_ready, 0);
      expq.delete();
      for (int i = 0; i < SL-1; i++) hist[i] = 0;
      ready_at = -1;
      idle(2);
      #2 rstb = 1'b1;
      idle(3);
      clear_errv(); errv[0] = 3; errv[1] = -4; send();
      idle(2);
      check_val("post_rst_lane0_ener", bus.flag_eners[0], 9);

      // Randomized bursts; margin only changes while the pipeline is empty.
      for (int b = 0; b < 14; b++) begin
         random_cfg();
         cfg_update = 1'b1;
         tick();
         random_cfg();
         for (int t = 0; t < 28; t++) begin
            if ($urandom_range(0, 39) == 0) begin random_cfg(); cfg_update = 1'b1; end
            if ($urandom_range(0, 9) < 7) begin
               for (int i = 0; i < WIDTH; i++) errv[i] = int'($urandom_range(0, 80)) - 40;
               if ($urandom_range(0, 3) == 0)
                  for (int i = 0; i < WIDTH; i++) errv[i] = int'($urandom_range(0, 511)) - 256;
               if ($urandom_range(0, 1) == 1) begin
                  i0 = int'($urandom_range(0, WIDTH - SL));
                  c  = int'($urandom_range(0, NC - 1));
                  for (int k = 0; k < SL; k++) errv[i0+k] = ies_ref[c][k] + int'($urandom_range(0, 2)) - 1;
               end
               send();
            end else begin
               tick();
            end
         end
         idle(3);
         ener_margin = ($urandom_range(0, 4) == 0) ? EB'($urandom) : EB'($urandom_range(0, 300));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
